// File: rtl/mmss_timer_ctrl.sv
// Control FSM and tick scheduler for an mm:ss timer driving two cascaded 00..59 BCD counters.
// Handles STOP/RUN/SET modes, the 1 Hz tick, the counter clear and the set-mode blink.
module mmss_timer_ctrl #(
  parameter int unsigned TICK_DIV  = 20_000_000,
  parameter int unsigned BLINK_DIV = 5_000_000
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_start_stop,
  input  logic       i_mode,
  input  logic       i_inc,
  input  logic       i_clr,
  input  logic       i_sec_carry,
  input  logic       i_min_carry,
  output logic       o_sec_enable,
  output logic       o_min_enable,
  output logic       o_cnt_clear,
  output logic       o_wrap,
  output logic       o_blink,
  output logic [1:0] o_state
);

  localparam int unsigned TickW  = $clog2(TICK_DIV);
  localparam int unsigned BlinkW = $clog2(BLINK_DIV);
  localparam logic [TickW-1:0]  TickMax  = TickW'(TICK_DIV - 1);
  localparam logic [BlinkW-1:0] BlinkMax = BlinkW'(BLINK_DIV - 1);

  typedef enum logic [1:0] {
    StStop   = 2'd0,
    StRun    = 2'd1,
    StSetSec = 2'd2,
    StSetMin = 2'd3
  } state_e;

  state_e              r_state;
  logic [TickW-1:0]    r_presc;
  logic [BlinkW-1:0]   r_bcnt;
  logic                r_sec_en;
  logic                r_min_en;
  logic                r_clear;
  logic                r_wrap;
  logic                r_blink;

  state_e              w_state_next;
  logic [TickW-1:0]    w_presc_next;
  logic [BlinkW-1:0]   w_bcnt_next;
  logic                w_sec_en_next;
  logic                w_min_en_next;
  logic                w_clear_next;
  logic                w_wrap_next;
  logic                w_blink_next;
  logic                w_tick;
  logic                w_set_next;

  assign w_tick = (r_state == StRun) && (r_presc == TickMax);

  always_comb begin
    w_state_next  = r_state;
    w_sec_en_next = 1'b0;
    w_min_en_next = 1'b0;
    w_clear_next  = 1'b0;
    w_wrap_next   = 1'b0;
    // Buttons are prioritised start_stop > mode > inc/clr, so one action per cycle.
    case (r_state)
      StStop: begin
        if (i_start_stop)  w_state_next = StRun;
        else if (i_mode)   w_state_next = StSetSec;
        else if (i_clr)    w_clear_next = 1'b1;
      end
      StRun: begin
        if (i_start_stop) w_state_next = StStop;
        w_sec_en_next = w_tick;
        w_min_en_next = w_tick & i_sec_carry;
        w_wrap_next   = w_tick & i_sec_carry & i_min_carry;
      end
      StSetSec: begin
        if (i_start_stop)  w_state_next  = StRun;
        else if (i_mode)   w_state_next  = StSetMin;
        else if (i_inc)    w_sec_en_next = 1'b1;
      end
      StSetMin: begin
        if (i_start_stop)  w_state_next  = StRun;
        else if (i_mode)   w_state_next  = StStop;
        else if (i_inc)    w_min_en_next = 1'b1;
      end
      default: w_state_next = StStop;
    endcase
  end

  // Prescaler only runs while staying in RUN; any exit discards the partial count.
  always_comb begin
    w_presc_next = '0;
    if (r_state == StRun && w_state_next == StRun) begin
      w_presc_next = w_tick ? '0 : r_presc + 1'b1;
    end
  end

  assign w_set_next = (w_state_next == StSetSec) || (w_state_next == StSetMin);

  // Entering a SET state (including SET_SEC -> SET_MIN) restarts the blink phase.
  always_comb begin
    w_bcnt_next  = '0;
    w_blink_next = 1'b1;
    if (w_set_next && (w_state_next == r_state)) begin
      if (r_bcnt == BlinkMax) begin
        w_blink_next = ~r_blink;
      end else begin
        w_bcnt_next  = r_bcnt + 1'b1;
        w_blink_next = r_blink;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state  <= StStop;
      r_presc  <= '0;
      r_bcnt   <= '0;
      r_sec_en <= 1'b0;
      r_min_en <= 1'b0;
      r_clear  <= 1'b0;
      r_wrap   <= 1'b0;
      r_blink  <= 1'b1;
    end else begin
      r_state  <= w_state_next;
      r_presc  <= w_presc_next;
      r_bcnt   <= w_bcnt_next;
      r_sec_en <= w_sec_en_next;
      r_min_en <= w_min_en_next;
      r_clear  <= w_clear_next;
      r_wrap   <= w_wrap_next;
      r_blink  <= w_blink_next;
    end
  end

  assign o_sec_enable = r_sec_en;
  assign o_min_enable = r_min_en;
  assign o_cnt_clear  = r_clear;
  assign o_wrap       = r_wrap;
  assign o_blink      = r_blink;
  assign o_state      = r_state;

endmodule
